dot_product_engine: RTL and testbench

- Parametrised, streaming successor to the fixed 16-lane ROM-fed matrix dot-product block.
- Accepts LANES operand pairs per beat over a valid/ready stream and multiplies them in parallel.
- Reduces the products through a registered adder tree and accumulates a len-element unsigned dot product.
- Reports result, overflow and cycle count through a start/busy/result_valid handshake; sits between operand memory readers and the display/result registers.

---
 rtl/dot_product_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_dot_product_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine.sv
// Streaming unsigned dot-product engine. Takes LANES operand pairs per beat
// over a valid/ready stream, multiplies them in parallel and reduces the
// products through a registered adder tree. It accumulates a len-element sum
// and reports result, sticky overflow and the RUN+DRAIN cycle count.
module dot_product_engine #(
   parameter int LANES    = 16,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 16,
   parameter int LEN_W    = 13,
   parameter int SATURATE = 0
) (
   input  logic                    clock,
   input  logic                    reset_l,
   input  logic                    start,
   input  logic [LEN_W-1:0]        len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] a_data,
   input  logic [LANES*DATA_W-1:0] b_data,
   output logic                    busy,
   output logic [ACC_W-1:0]        result,
   output logic                    result_valid,
   output logic                    overflow,
   output logic [15:0]             cycle_count
);

   localparam int LG     = $clog2(LANES);
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + LG;
   // One bit wider than the larger addend so the carry out is never lost.
   localparam int NEXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
   localparam int BL_W   = LEN_W + 1;
   localparam int VEC_W  = LANES * DATA_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic                         start_accept;
   logic                         enter_done;
   logic                         xfer;
   logic                         final_beat;
   logic [BL_W-1:0]              beats_init;
   logic [BL_W-1:0]              beats_left_q;
   logic [LG-1:0]                last_lanes_q;
   logic [LANES-1:0]             lane_keep;
   logic [VEC_W-1:0]             a_masked, b_masked;
   logic [VEC_W-1:0]             s1_a_q, s1_b_q;
   logic                         s1_valid_q, s2_valid_q, s3_valid_q;
   logic [LANES*PROD_W-1:0]      prod_d, prod_q;
   logic [(2*LANES-1)*SUM_W-1:0] tree_node;
   logic [SUM_W-1:0]             s3_sum_q;
   logic [NEXT_W-1:0]            acc_next;
   logic                         acc_ovf;
   logic [ACC_W-1:0]             acc_q, acc_d;
   logic [ACC_W-1:0]             result_q;
   logic                         result_valid_q;
   logic                         overflow_q;
   logic [15:0]                  cycle_count_q;

   // Beats needed for the job: ceil(len / LANES).
   assign beats_init = (BL_W'(len) + BL_W'(LANES - 1)) >> LG;
   assign final_beat = (beats_left_q == BL_W'(1));

   // Per-lane masking of the final beat, then one multiplier per lane.
   // The adder tree is heap-ordered: node k sums nodes 2k+1 and 2k+2,
   // leaves sit at LANES-1 .. 2*LANES-2, the root is node 0.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_keep[gi] = !(final_beat && (last_lanes_q != '0) &&
                                  (last_lanes_q <= LG'(gi)));
         assign a_masked[gi*DATA_W +: DATA_W] =
            lane_keep[gi] ? a_data[gi*DATA_W +: DATA_W] : '0;
         assign b_masked[gi*DATA_W +: DATA_W] =
            lane_keep[gi] ? b_data[gi*DATA_W +: DATA_W] : '0;
         assign prod_d[gi*PROD_W +: PROD_W] =
            PROD_W'(s1_a_q[gi*DATA_W +: DATA_W]) * PROD_W'(s1_b_q[gi*DATA_W +: DATA_W]);
         assign tree_node[(LANES-1+gi)*SUM_W +: SUM_W] =
            {{LG{1'b0}}, prod_q[gi*PROD_W +: PROD_W]};
      end
      for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_tree
         assign tree_node[gi*SUM_W +: SUM_W] =
            tree_node[(2*gi+1)*SUM_W +: SUM_W] + tree_node[(2*gi+2)*SUM_W +: SUM_W];
      end
   endgenerate

   // Next-state and handshake decode; DRAIN ends when the last beat sits in S3.
   always_comb begin
      state_d      = state_q;
      start_accept = 1'b0;
      enter_done   = 1'b0;
      xfer         = 1'b0;
      in_ready     = 1'b0;
      busy         = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               start_accept = 1'b1;
               if (len == '0) begin
                  state_d    = ST_DONE;
                  enter_done = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            xfer     = in_valid;
            if (in_valid && final_beat) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (!s1_valid_q && !s2_valid_q) begin
               state_d    = ST_DONE;
               enter_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job bookkeeping: beats still to accept and the lane count of the last beat.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         beats_left_q <= '0;
         last_lanes_q <= '0;
      end else if (start_accept) begin
         beats_left_q <= beats_init;
         last_lanes_q <= len[LG-1:0];
      end else if (xfer) begin
         beats_left_q <= beats_left_q - BL_W'(1);
      end
   end

   // S1: capture the accepted beat with out-of-range lanes zeroed.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
      end else begin
         s1_valid_q <= xfer;
         if (xfer) begin
            s1_a_q <= a_masked;
            s1_b_q <= b_masked;
         end
      end
   end

   // S2 products and S3 full-width tree sum, each tagged with a valid bit.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         s2_valid_q <= 1'b0;
         prod_q     <= '0;
         s3_valid_q <= 1'b0;
         s3_sum_q   <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         prod_q     <= prod_d;
         s3_valid_q <= s2_valid_q;
         s3_sum_q   <= tree_node[SUM_W-1:0];
      end
   end

   // Accumulator update with carry detection; wraps or clamps on overflow.
   always_comb begin
      acc_next = NEXT_W'(acc_q) + NEXT_W'(s3_sum_q);
      acc_ovf  = |acc_next[NEXT_W-1:ACC_W];
      acc_d    = acc_q;
      if (start_accept) begin
         acc_d = '0;
      end else if (s3_valid_q) begin
         if ((SATURATE != 0) && acc_ovf) begin
            acc_d = '1;
         end else begin
            acc_d = acc_next[ACC_W-1:0];
         end
      end
   end

   // Accumulator, published result, completion pulse, overflow and cycle count.
   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         acc_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
         cycle_count_q  <= '0;
      end else begin
         acc_q          <= acc_d;
         result_valid_q <= enter_done;
         if (enter_done) begin
            result_q <= acc_d;
         end
         if (start_accept) begin
            overflow_q <= 1'b0;
         end else if (s3_valid_q && acc_ovf) begin
            overflow_q <= 1'b1;
         end
         if (start_accept) begin
            cycle_count_q <= '0;
         end else if (busy && (cycle_count_q != 16'hFFFF)) begin
            cycle_count_q <= cycle_count_q + 16'd1;
         end
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign overflow     = overflow_q;
   assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: a wrapping and a saturating instance share
// one stimulus stream. A job-level model (sum of element products, beats
// accepted whenever valid, three drain cycles) is compared every cycle, and
// the directed jobs also pin literal expectations.
module tb_dot_product_engine;

   localparam int LANES  = 16;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int LEN_W  = 13;
   localparam int VEC_W  = LANES * DATA_W;

   logic             clock    = 1'b0;
   logic             reset_l  = 1'b0;
   logic             start    = 1'b0;
   logic [LEN_W-1:0] len      = '0;
   logic             in_valid = 1'b0;
   logic [VEC_W-1:0] a_data   = '0;
   logic [VEC_W-1:0] b_data   = '0;

   logic             in_ready_w, busy_w, rv_w, ovf_w;
   logic [ACC_W-1:0] result_w;
   logic [15:0]      cc_w;
   logic             in_ready_s, busy_s, rv_s, ovf_s;
   logic [ACC_W-1:0] result_s;
   logic [15:0]      cc_s;

   int total = 0;
   int bad   = 0;

   dot_product_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W),
                        .LEN_W(LEN_W), .SATURATE(0)) dut_w (
      .clock(clock), .reset_l(reset_l), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_w), .a_data(a_data), .b_data(b_data),
      .busy(busy_w), .result(result_w), .result_valid(rv_w),
      .overflow(ovf_w), .cycle_count(cc_w)
   );

   dot_product_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W),
                        .LEN_W(LEN_W), .SATURATE(1)) dut_s (
      .clock(clock), .reset_l(reset_l), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready_s), .a_data(a_data), .b_data(b_data),
      .busy(busy_s), .result(result_s), .result_valid(rv_s),
      .overflow(ovf_s), .cycle_count(cc_s)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sum of a*b over the lanes of one beat whose element index is below len.
   function automatic longint beat_sum(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                       input int kbase, input int l);
      longint s;
      s = 0;
      for (int i = 0; i < LANES; i++) begin
         if (kbase + i < l) begin
            s += longint'(a[i*DATA_W +: DATA_W]) * longint'(b[i*DATA_W +: DATA_W]);
         end
      end
      return s;
   endfunction

   // Job-level reference model.
   logic        m_busy  = 1'b0;
   logic        m_ready = 1'b0;
   logic        m_rv    = 1'b0;
   logic        m_ovf   = 1'b0;
   logic [15:0] m_res_w = '0;
   logic [15:0] m_res_s = '0;
   logic [15:0] m_cc    = '0;
   int          m_len   = 0;
   int          m_left  = 0;
   int          m_drain = 0;
   int          m_cyc   = 0;
   int          m_kbase = 0;
   longint      m_sum   = 0;

   // Model update: start, beat acceptance, and completion three cycles after the last beat.
   always @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         m_busy <= 1'b0; m_ready <= 1'b0; m_rv <= 1'b0; m_ovf <= 1'b0;
         m_res_w <= '0; m_res_s <= '0; m_cc <= '0;
         m_len <= 0; m_left <= 0; m_drain <= 0; m_cyc <= 0; m_kbase <= 0; m_sum <= 0;
      end else begin
         m_rv <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_ovf   <= 1'b0;
               m_cc    <= '0;
               m_sum   <= 0;
               m_kbase <= 0;
               m_cyc   <= 0;
               m_len   <= int'(len);
               if (len == '0) begin
                  m_rv    <= 1'b1;
                  m_res_w <= '0;
                  m_res_s <= '0;
               end else begin
                  m_busy  <= 1'b1;
                  m_ready <= 1'b1;
                  m_left  <= (int'(len) + LANES - 1) / LANES;
               end
            end
         end else begin
            m_cyc <= m_cyc + 1;
            if (m_ready) begin
               if (in_valid) begin
                  m_sum   <= m_sum + beat_sum(a_data, b_data, m_kbase, m_len);
                  m_kbase <= m_kbase + LANES;
                  m_left  <= m_left - 1;
                  if (m_left == 1) begin
                     m_ready <= 1'b0;
                     m_drain <= 3;
                  end
               end
            end else if (m_drain == 1) begin
               m_busy  <= 1'b0;
               m_rv    <= 1'b1;
               m_res_w <= 16'(m_sum);
               m_res_s <= (m_sum > 65535) ? 16'hFFFF : 16'(m_sum);
               m_ovf   <= (m_sum > 65535);
               m_cc    <= (m_cyc + 1 > 65535) ? 16'hFFFF : 16'(m_cyc + 1);
            end else begin
               m_drain <= m_drain - 1;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      chk("in_ready_w", in_ready_w, m_ready);
      chk("in_ready_s", in_ready_s, m_ready);
      chk("busy_w", busy_w, m_busy);
      chk("busy_s", busy_s, m_busy);
      chk("result_valid_w", rv_w, m_rv);
      chk("result_valid_s", rv_s, m_rv);
      chk("result_w", result_w, m_res_w);
      chk("result_s", result_s, m_res_s);
      if (!m_busy) begin
         chk("overflow_w", ovf_w, m_ovf);
         chk("overflow_s", ovf_s, m_ovf);
         chk("cycle_count_w", cc_w, m_cc);
         chk("cycle_count_s", cc_s, m_cc);
      end
   end

   // dmode 0: every lane av/bv; otherwise random bytes per lane.
   task automatic drive_data(input int dmode, input int av, input int bv);
      for (int i = 0; i < LANES; i++) begin
         if (dmode == 0) begin
            a_data[i*DATA_W +: DATA_W] = DATA_W'(av);
            b_data[i*DATA_W +: DATA_W] = DATA_W'(bv);
         end else begin
            a_data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
            b_data[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
         end
      end
   endtask

   // One job. vmode 0: valid held high, 1: toggling starting high, 2: random.
   // cyc returns the cycle index (0 = first cycle after start) of result_valid.
   task automatic run_job(input int l, input int vmode, input int dmode, input int av,
                          input int bv, input bit mid_start, output int cyc);
      @(posedge clock); #1;
      start    = 1'b1;
      len      = LEN_W'(l);
      in_valid = 1'b0;
      drive_data(dmode, av, bv);
      @(posedge clock); #1;
      start = 1'b0;
      cyc   = -1;
      for (int i = 0; i < 20000; i++) begin
         case (vmode)
            0:       in_valid = 1'b1;
            1:       in_valid = ((i % 2) == 0);
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         drive_data(dmode, av, bv);
         if (mid_start && i == 3) begin
            start = 1'b1;
            len   = LEN_W'(7);
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         if (rv_w) begin
            cyc = i;
            break;
         end
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (cyc < 0) begin
         total++;
         bad++;
         $display("FAIL job_timeout actual=no result_valid required=result_valid len=%0d", l);
      end
      $display("job len=%0d vmode=%0d result_w=0x%0h result_s=0x%0h ovf=%0b cycle_count=%0d done_at=%0d",
               l, vmode, result_w, result_s, ovf_w, cc_w, cyc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;

      // Reset state.
      reset_l = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", in_ready_w, 0);
      chk("rst_busy", busy_w, 0);
      chk("rst_result", result_w, 0);
      chk("rst_result_valid", rv_w, 0);
      chk("rst_overflow", ovf_w, 0);
      chk("rst_cycle_count", cc_w, 0);
      @(posedge clock); #1;
      reset_l = 1'b1;

      // 16 elements of 1*2.
      run_job(16, 0, 0, 1, 2, 1'b0, cyc);
      chk("basic_result_w", result_w, 32);
      chk("basic_result_s", result_s, 32);
      chk("basic_overflow", ovf_w, 0);
      chk("basic_cycle_count", cc_w, 4);
      @(negedge clock);
      chk("basic_pulse_width", rv_w, 0);

      // 4096 elements of 1*1: 256 beats plus 3 drain cycles.
      run_job(4096, 0, 0, 1, 1, 1'b0, cyc);
      chk("long_result", result_w, 16'h1000);
      chk("long_cycle_count", cc_w, 259);
      @(negedge clock);
      chk("long_busy_after", busy_w, 0);

      // Partial beat: only lanes 0..4 count, 5*12.
      run_job(5, 0, 0, 3, 4, 1'b0, cyc);
      chk("partial_result", result_w, 60);

      // 16 * 255 * 255 = 0xFE010.
      run_job(16, 0, 0, 255, 255, 1'b0, cyc);
      chk("ovf_wrap_result", result_w, 16'hE010);
      chk("ovf_wrap_flag", ovf_w, 1);
      chk("ovf_sat_result", result_s, 16'hFFFF);
      chk("ovf_sat_flag", ovf_s, 1);

      // len=0 completes in the cycle after start with a zero result.
      run_job(0, 0, 0, 9, 9, 1'b0, cyc);
      chk("len0_latency", cyc, 0);
      chk("len0_result", result_w, 0);
      chk("len0_overflow", ovf_w, 0);

      // Toggling valid with a stray start: beats land on RUN cycles 1,3,5,7,
      // so 7 RUN cycles plus 3 DRAIN cycles.
      run_job(64, 1, 0, 2, 2, 1'b1, cyc);
      chk("stall_result", result_w, 256);
      chk("stall_cycle_count", cc_w, 10);

      // Reset after two accepted beats abandons the job.
      @(posedge clock); #1;
      start = 1'b1; len = LEN_W'(64); in_valid = 1'b0;
      drive_data(0, 1, 1);
      @(posedge clock); #1;
      start = 1'b0; in_valid = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset_l  = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      chk("midrst_busy", busy_w, 0);
      chk("midrst_in_ready", in_ready_w, 0);
      chk("midrst_result", result_w, 0);
      chk("midrst_cycle_count", cc_w, 0);
      @(posedge clock); #1;
      reset_l = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk("midrst_no_result_valid", rv_w, 0);
      end

      // Random jobs against the model.
      for (int j = 0; j < 12; j++) begin
         run_job(int'($urandom_range(0, 300)), int'($urandom_range(0, 2)), 1, 0, 0, 1'b0, cyc);
      end

      repeat (2) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
